// File: rtl/orpsoc_wb_pkg.sv
// orpsoc_wb_pkg: shared Wishbone burst tags, master indices and arbiter state encoding
package orpsoc_wb_pkg;
  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR = 3'b010;
  localparam logic [2:0] CTI_EOB = 3'b111;
  localparam int M_DBUS = 0;
  localparam int M_IBUS = 1;
  localparam int M_DBG = 2;
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, TOERR = 2'd2} arb_state_t;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: one-hot round-robin winner, searching upward from last+1 and wrapping
module rr_pick #(
  parameter int NM = 3,
  parameter int LW = (NM > 1) ? $clog2(NM) : 1
) (
  input  logic [NM-1:0] req,
  input  logic [LW-1:0] last,
  output logic [NM-1:0] win
);
  always_comb begin
    win = '0;
    for (int k = NM; k >= 1; k--) begin
      if (req[(int'(last) + k) % NM]) begin
        win = '0;
        win[(int'(last) + k) % NM] = 1'b1;
      end
    end
  end
endmodule

// File: rtl/wb_mem_arbiter.sv
// wb_mem_arbiter: round-robin Wishbone B3 arbiter holding each grant for the owner's whole cyc,
// with a per-access watchdog that terminates hung slave accesses with err.
module wb_mem_arbiter
  import orpsoc_wb_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int NM = 3,
  parameter int TIMEOUT = 255
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic [NM*AW-1:0]     m_adr_i,
  input  logic [NM*DW-1:0]     m_dat_i,
  input  logic [NM*DW/8-1:0]   m_sel_i,
  input  logic [NM-1:0]        m_we_i,
  input  logic [NM-1:0]        m_cyc_i,
  input  logic [NM-1:0]        m_stb_i,
  input  logic [NM*3-1:0]      m_cti_i,
  input  logic [NM*2-1:0]      m_bte_i,
  output logic [DW-1:0]        m_dat_o,
  output logic [NM-1:0]        m_ack_o,
  output logic [NM-1:0]        m_err_o,
  output logic [NM-1:0]        m_rty_o,
  output logic [AW-1:0]        s_adr_o,
  output logic [DW-1:0]        s_dat_o,
  output logic [DW/8-1:0]      s_sel_o,
  output logic                 s_we_o,
  output logic                 s_cyc_o,
  output logic                 s_stb_o,
  output logic [2:0]           s_cti_o,
  output logic [1:0]           s_bte_o,
  input  logic [DW-1:0]        s_dat_i,
  input  logic                 s_ack_i,
  input  logic                 s_err_i,
  input  logic                 s_rty_i,
  output logic [NM-1:0]        grant_o,
  output logic                 to_valid_o,
  output logic [AW-1:0]        to_adr_o,
  input  logic                 to_clr_i
);
  localparam int SW = DW / 8;
  localparam int LW = (NM > 1) ? $clog2(NM) : 1;
  localparam int CW = $clog2(TIMEOUT);
  arb_state_t state, state_n;
  logic [NM-1:0] grant_n, win;
  logic [LW-1:0] last, last_n, gidx;
  logic [CW-1:0] cnt, cnt_n;
  logic to_valid_n, g_cyc, g_stb, term, busy;
  logic [AW-1:0] to_adr_n;
  rr_pick #(.NM(NM), .LW(LW)) u_pick (.req(m_cyc_i), .last(last), .win(win));
  assign term = s_ack_i | s_err_i | s_rty_i;
  assign busy = state == BUSY;
  assign m_dat_o = s_dat_i;
  assign m_ack_o = busy ? grant_o & {NM{s_ack_i}} : '0;
  assign m_rty_o = busy ? grant_o & {NM{s_rty_i}} : '0;
  assign m_err_o = (state == TOERR) ? grant_o : busy ? grant_o & {NM{s_err_i}} : '0;
  // AND-OR mux on the one-hot grant; no grant means an all-zero slave request
  always_comb begin
    gidx = '0;
    g_cyc = 1'b0;
    g_stb = 1'b0;
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    s_we_o = 1'b0;
    s_cti_o = '0;
    s_bte_o = '0;
    for (int i = 0; i < NM; i++) begin
      if (grant_o[i]) begin
        gidx = LW'(i);
        g_cyc = m_cyc_i[i];
        g_stb = m_stb_i[i];
        s_adr_o = m_adr_i[i*AW +: AW];
        s_dat_o = m_dat_i[i*DW +: DW];
        s_sel_o = m_sel_i[i*SW +: SW];
        s_we_o = m_we_i[i];
        s_cti_o = m_cti_i[i*3 +: 3];
        s_bte_o = m_bte_i[i*2 +: 2];
      end
    end
    s_cyc_o = state != TOERR && g_cyc;
    s_stb_o = state != TOERR && g_stb;
  end
  always_comb begin
    state_n = state;
    grant_n = grant_o;
    last_n = last;
    cnt_n = '0;
    to_valid_n = to_valid_o & ~to_clr_i;
    to_adr_n = to_adr_o;
    if (state == IDLE) begin
      if (|m_cyc_i) begin
        state_n = BUSY;
        grant_n = win;
      end
    end else if (state == BUSY) begin
      cnt_n = (g_stb && !term) ? cnt + 1'b1 : '0;
      if (!g_cyc) begin
        state_n = IDLE;
        grant_n = '0;
        last_n = gidx;
        cnt_n = '0;
      end else if (g_stb && !term && cnt == CW'(TIMEOUT - 1)) begin
        state_n = TOERR;
        cnt_n = '0;
      end
    end else begin
      // a fresh timeout beats a same-cycle clear; only the first address is kept
      to_valid_n = 1'b1;
      to_adr_n = to_valid_o ? to_adr_o : s_adr_o;
      state_n = g_cyc ? BUSY : IDLE;
      grant_n = g_cyc ? grant_o : '0;
      last_n = g_cyc ? last : gidx;
    end
  end
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state <= IDLE;
      grant_o <= '0;
      last <= LW'(NM - 1);
      cnt <= '0;
      to_valid_o <= 1'b0;
      to_adr_o <= '0;
    end else begin
      state <= state_n;
      grant_o <= grant_n;
      last <= last_n;
      cnt <= cnt_n;
      to_valid_o <= to_valid_n;
      to_adr_o <= to_adr_n;
    end
  end
endmodule

// File: tb/tb_wb_mem_arbiter.sv
// tb_wb_mem_arbiter: scenario tasks plus randomized rounds checked against a round-robin order model
module tb_wb_mem_arbiter;
  import orpsoc_wb_pkg::*;
  localparam int AW = 32, DW = 32, NM = 3, SW = DW / 8, TIMEOUT = 16;
  logic wb_clk_i = 1'b0, wb_rst_i = 1'b0;
  logic [NM*AW-1:0] m_adr_i;
  logic [NM*DW-1:0] m_dat_i;
  logic [NM*SW-1:0] m_sel_i;
  logic [NM*3-1:0] m_cti_i;
  logic [NM*2-1:0] m_bte_i;
  logic [NM-1:0] we, cyc, stb;
  logic [AW-1:0] adr [NM];
  logic [DW-1:0] dat [NM];
  logic [SW-1:0] sel [NM];
  logic [2:0] cti [NM];
  logic [1:0] bte [NM];
  logic [DW-1:0] m_dat_o, s_dat_o, s_dat_i;
  logic [NM-1:0] m_ack_o, m_err_o, m_rty_o, grant_o;
  logic [AW-1:0] s_adr_o, to_adr_o;
  logic [SW-1:0] s_sel_o;
  logic s_we_o, s_cyc_o, s_stb_o, s_ack_i, s_err_i, s_rty_i, to_valid_o, to_clr_i;
  logic [2:0] s_cti_o;
  logic [1:0] s_bte_o;
  int vectors = 0, miscompares = 0, exp_last = NM - 1;
  for (genvar g = 0; g < NM; g++) begin : pk
    assign m_adr_i[g*AW +: AW] = adr[g];
    assign m_dat_i[g*DW +: DW] = dat[g];
    assign m_sel_i[g*SW +: SW] = sel[g];
    assign m_cti_i[g*3 +: 3] = cti[g];
    assign m_bte_i[g*2 +: 2] = bte[g];
  end
  wb_mem_arbiter #(.AW(AW), .DW(DW), .NM(NM), .TIMEOUT(TIMEOUT)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i), .m_we_i(we), .m_cyc_i(cyc), .m_stb_i(stb),
    .m_cti_i(m_cti_i), .m_bte_i(m_bte_i), .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rty_o(m_rty_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
    .s_cti_o(s_cti_o), .s_bte_o(s_bte_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i),
    .grant_o(grant_o), .to_valid_o(to_valid_o), .to_adr_o(to_adr_o), .to_clr_i(to_clr_i)
  );
  always #5 wb_clk_i = ~wb_clk_i;
  task automatic tick();
    @(posedge wb_clk_i);
    #1;
  endtask
  task automatic smp();
    @(negedge wb_clk_i);
  endtask
  task automatic idle_inputs();
    for (int i = 0; i < NM; i++) begin
      adr[i] = '0; dat[i] = '0; sel[i] = '0; cti[i] = CTI_CLASSIC; bte[i] = '0;
    end
    we = '0; cyc = '0; stb = '0;
    s_dat_i = '0; s_ack_i = 1'b0; s_err_i = 1'b0; s_rty_i = 1'b0; to_clr_i = 1'b0;
  endtask
  task automatic do_reset();
    idle_inputs();
    wb_rst_i = 1'b1;
    tick(); tick();
    wb_rst_i = 1'b0;
    exp_last = NM - 1;
    tick();
  endtask
  task automatic test_reset();
    idle_inputs();
    wb_rst_i = 1'b1;
    #2;
    vectors++; if (grant_o !== '0) begin miscompares++; $display("FAIL reset_grant got %b want 000", grant_o); end
    vectors++; if (to_adr_o !== '0) begin miscompares++; $display("FAIL reset_to_adr got %h want 0", to_adr_o); end
    tick();
    wb_rst_i = 1'b0;
    tick(); smp();
    vectors++; if (grant_o !== '0 || s_cyc_o !== 1'b0 || s_stb_o !== 1'b0) begin miscompares++; $display("FAIL idle_bus grant %b cyc %b stb %b want 0 0 0", grant_o, s_cyc_o, s_stb_o); end
    vectors++; if (to_valid_o !== 1'b0 || m_ack_o !== '0) begin miscompares++; $display("FAIL idle_status to_valid %b ack %b want 0 000", to_valid_o, m_ack_o); end
  endtask
  task automatic test_single();
    logic [DW-1:0] rd;
    tick();
    cyc[M_IBUS] = 1'b1; stb[M_IBUS] = 1'b1; adr[M_IBUS] = 32'h100; we[M_IBUS] = 1'b0; sel[M_IBUS] = '1;
    smp();
    vectors++; if (s_cyc_o !== 1'b0) begin miscompares++; $display("FAIL single_latency s_cyc got %b want 0", s_cyc_o); end
    tick(); smp();
    vectors++; if (s_cyc_o !== 1'b1 || grant_o !== 3'b010 || s_adr_o !== 32'h100) begin miscompares++; $display("FAIL single_grant cyc %b grant %b adr %h want 1 010 100", s_cyc_o, grant_o, s_adr_o); end
    tick(); smp();
    vectors++; if (m_ack_o !== '0) begin miscompares++; $display("FAIL single_noack got %b want 000", m_ack_o); end
    tick();
    rd = $urandom; s_ack_i = 1'b1; s_dat_i = rd;
    smp();
    vectors++; if (m_ack_o !== 3'b010 || m_dat_o !== rd) begin miscompares++; $display("FAIL single_ack ack %b dat %h want 010 %h", m_ack_o, m_dat_o, rd); end
    tick();
    s_ack_i = 1'b0; cyc[M_IBUS] = 1'b0; stb[M_IBUS] = 1'b0;
    smp();
    vectors++; if (m_ack_o !== '0 || s_cyc_o !== 1'b0) begin miscompares++; $display("FAIL single_drop ack %b cyc %b want 000 0", m_ack_o, s_cyc_o); end
    tick(); smp();
    vectors++; if (grant_o !== '0) begin miscompares++; $display("FAIL single_release grant %b want 000", grant_o); end
    exp_last = M_IBUS;
  endtask
  // requesters in req all raise cyc together; the model expects service in round-robin order from exp_last
  task automatic run_round(input logic [NM-1:0] req, input string tag);
    int order[$];
    logic [DW-1:0] rd;
    logic [NM-1:0] oh;
    int m, lat;
    for (int k = 1; k <= NM; k++) if (req[(exp_last + k) % NM]) order.push_back((exp_last + k) % NM);
    tick();
    for (int i = 0; i < NM; i++) begin
      if (req[i]) begin
        adr[i] = $urandom; dat[i] = $urandom; sel[i] = SW'($urandom); cti[i] = 3'($urandom); bte[i] = 2'($urandom);
        we[i] = 1'($urandom); cyc[i] = 1'b1; stb[i] = 1'b1;
      end
    end
    smp();
    vectors++; if (grant_o !== '0) begin miscompares++; $display("FAIL %s latency grant %b want 000", tag, grant_o); end
    for (int j = 0; j < order.size(); j++) begin
      m = order[j];
      oh = NM'(1) << m;
      tick(); smp();
      vectors++; if (grant_o !== oh || s_cyc_o !== 1'b1) begin miscompares++; $display("FAIL %s grant got %b cyc %b want %b 1", tag, grant_o, s_cyc_o, oh); end
      vectors++; if (s_adr_o !== adr[m] || s_dat_o !== dat[m] || s_sel_o !== sel[m] || s_we_o !== we[m] || s_cti_o !== cti[m] || s_bte_o !== bte[m]) begin
        miscompares++; $display("FAIL %s slave_mux adr %h dat %h sel %h we %b want %h %h %h %b", tag, s_adr_o, s_dat_o, s_sel_o, s_we_o, adr[m], dat[m], sel[m], we[m]);
      end
      lat = $urandom_range(0, 3);
      for (int w = 0; w < lat; w++) begin
        tick(); smp();
        vectors++; if (m_ack_o !== '0) begin miscompares++; $display("FAIL %s early_ack got %b want 000", tag, m_ack_o); end
      end
      tick();
      rd = $urandom; s_ack_i = 1'b1; s_dat_i = rd;
      smp();
      vectors++; if (m_ack_o !== oh || m_err_o !== '0 || m_dat_o !== rd) begin miscompares++; $display("FAIL %s ack got %b err %b dat %h want %b 000 %h", tag, m_ack_o, m_err_o, m_dat_o, oh, rd); end
      tick();
      s_ack_i = 1'b0; cyc[m] = 1'b0; stb[m] = 1'b0;
      smp();
      vectors++; if (grant_o !== oh || s_cyc_o !== 1'b0) begin miscompares++; $display("FAIL %s drop grant %b cyc %b want %b 0", tag, grant_o, s_cyc_o, oh); end
      exp_last = m;
      tick(); smp();
      vectors++; if (grant_o !== '0) begin miscompares++; $display("FAIL %s handover_gap grant %b want 000", tag, grant_o); end
    end
  endtask
  task automatic test_simultaneous();
    do_reset();
    run_round(3'b111, "sim_all");
    run_round(3'b101, "sim_0_2");
  endtask
  task automatic test_burst();
    logic [AW-1:0] base, ea;
    logic [DW-1:0] rd;
    logic [2:0] ec;
    do_reset();
    base = $urandom & 32'hFFFF_FFE0;
    tick();
    cyc[M_DBUS] = 1'b1; stb[M_DBUS] = 1'b1; cti[M_DBUS] = CTI_INCR; adr[M_DBUS] = base;
    cyc[M_DBG] = 1'b1; stb[M_DBG] = 1'b1; adr[M_DBG] = 32'hD000_0040;
    smp(); tick(); smp();
    vectors++; if (grant_o !== 3'b001) begin miscompares++; $display("FAIL burst_start grant %b want 001", grant_o); end
    for (int b = 0; b < 8; b++) begin
      tick();
      ea = base + AW'(4 * b); ec = (b == 7) ? CTI_EOB : CTI_INCR; rd = $urandom;
      adr[M_DBUS] = ea; cti[M_DBUS] = ec; s_ack_i = 1'b1; s_dat_i = rd;
      smp();
      vectors++; if (grant_o !== 3'b001 || m_ack_o !== 3'b001 || s_adr_o !== ea || s_cti_o !== ec || m_dat_o !== rd) begin
        miscompares++; $display("FAIL burst_beat%0d grant %b ack %b adr %h cti %b dat %h want 001 001 %h %b %h", b, grant_o, m_ack_o, s_adr_o, s_cti_o, m_dat_o, ea, ec, rd);
      end
    end
    tick();
    s_ack_i = 1'b0; cyc[M_DBUS] = 1'b0; stb[M_DBUS] = 1'b0;
    smp();
    vectors++; if (grant_o !== 3'b001) begin miscompares++; $display("FAIL burst_hold grant %b want 001", grant_o); end
    tick(); smp();
    vectors++; if (grant_o !== '0) begin miscompares++; $display("FAIL burst_gap grant %b want 000", grant_o); end
    tick(); smp();
    vectors++; if (grant_o !== 3'b100 || s_adr_o !== 32'hD000_0040) begin miscompares++; $display("FAIL burst_next grant %b adr %h want 100 d0000040", grant_o, s_adr_o); end
    tick(); s_ack_i = 1'b1; smp();
    vectors++; if (m_ack_o !== 3'b100) begin miscompares++; $display("FAIL burst_next_ack got %b want 100", m_ack_o); end
    tick(); s_ack_i = 1'b0; cyc[M_DBG] = 1'b0; stb[M_DBG] = 1'b0;
    tick(); smp();
    exp_last = M_DBG;
  endtask
  task automatic test_timeout();
    do_reset();
    tick();
    cyc[M_DBG] = 1'b1; stb[M_DBG] = 1'b1; we[M_DBG] = 1'b1; adr[M_DBG] = 32'hDEAD_0000;
    tick(); smp();
    vectors++; if (grant_o !== 3'b100 || s_stb_o !== 1'b1) begin miscompares++; $display("FAIL to_grant grant %b stb %b want 100 1", grant_o, s_stb_o); end
    for (int k = 1; k < TIMEOUT; k++) begin
      tick(); smp();
      vectors++; if (m_err_o !== '0) begin miscompares++; $display("FAIL to_early_err cycle %0d got %b want 000", k, m_err_o); end
    end
    tick(); smp();
    vectors++; if (m_err_o !== 3'b100 || s_cyc_o !== 1'b0 || s_stb_o !== 1'b0) begin miscompares++; $display("FAIL to_err err %b cyc %b stb %b want 100 0 0", m_err_o, s_cyc_o, s_stb_o); end
    tick();
    adr[M_DBG] = 32'hBEEF_0000;
    smp();
    vectors++; if (to_valid_o !== 1'b1 || to_adr_o !== 32'hDEAD_0000 || m_err_o !== '0 || s_cyc_o !== 1'b1) begin
      miscompares++; $display("FAIL to_status valid %b adr %h err %b cyc %b want 1 dead0000 000 1", to_valid_o, to_adr_o, m_err_o, s_cyc_o);
    end
    for (int k = 1; k < TIMEOUT; k++) begin tick(); smp(); end
    tick(); smp();
    vectors++; if (m_err_o !== 3'b100) begin miscompares++; $display("FAIL to_second_err got %b want 100", m_err_o); end
    tick(); smp();
    vectors++; if (to_adr_o !== 32'hDEAD_0000 || to_valid_o !== 1'b1) begin miscompares++; $display("FAIL to_keep_adr adr %h valid %b want dead0000 1", to_adr_o, to_valid_o); end
    tick(); cyc[M_DBG] = 1'b0; stb[M_DBG] = 1'b0;
    tick(); smp();
    tick(); to_clr_i = 1'b1;
    tick(); to_clr_i = 1'b0; smp();
    vectors++; if (to_valid_o !== 1'b0) begin miscompares++; $display("FAIL to_clear valid %b want 0", to_valid_o); end
    exp_last = M_DBG;
    tick();
    cyc[M_DBG] = 1'b1; stb[M_DBG] = 1'b1; adr[M_DBG] = 32'h200;
    tick(); smp();
    for (int k = 1; k < TIMEOUT - 1; k++) begin tick(); smp(); end
    tick(); s_ack_i = 1'b1; smp();
    vectors++; if (m_ack_o !== 3'b100 || m_err_o !== '0) begin miscompares++; $display("FAIL to_edge_ack ack %b err %b want 100 000", m_ack_o, m_err_o); end
    tick(); s_ack_i = 1'b0; cyc[M_DBG] = 1'b0; stb[M_DBG] = 1'b0; smp();
    vectors++; if (m_err_o !== '0) begin miscompares++; $display("FAIL to_edge_noerr err %b want 000", m_err_o); end
    tick(); smp();
    vectors++; if (to_valid_o !== 1'b0 || grant_o !== '0) begin miscompares++; $display("FAIL to_edge_status valid %b grant %b want 0 000", to_valid_o, grant_o); end
  endtask
  task automatic test_random();
    for (int r = 0; r < 20; r++) run_round(NM'($urandom_range(1, (1 << NM) - 1)), "rand");
  endtask
  task automatic test_reset_mid();
    do_reset();
    tick();
    cyc[M_DBUS] = 1'b1; stb[M_DBUS] = 1'b1; cti[M_DBUS] = CTI_INCR;
    cyc[M_IBUS] = 1'b1; stb[M_IBUS] = 1'b1; adr[M_IBUS] = 32'h4000;
    tick(); smp();
    vectors++; if (grant_o !== 3'b001) begin miscompares++; $display("FAIL rstmid_grant got %b want 001", grant_o); end
    tick(); s_ack_i = 1'b1;
    #2 wb_rst_i = 1'b1;
    #1;
    vectors++; if (s_cyc_o !== 1'b0 || grant_o !== '0 || m_ack_o !== '0) begin miscompares++; $display("FAIL rstmid_async cyc %b grant %b ack %b want 0 000 000", s_cyc_o, grant_o, m_ack_o); end
    smp(); tick();
    wb_rst_i = 1'b0; s_ack_i = 1'b0; cyc[M_DBUS] = 1'b0; stb[M_DBUS] = 1'b0;
    exp_last = NM - 1;
    smp();
    vectors++; if (grant_o !== '0) begin miscompares++; $display("FAIL rstmid_idle grant %b want 000", grant_o); end
    tick(); smp();
    vectors++; if (grant_o !== 3'b010 || s_adr_o !== 32'h4000) begin miscompares++; $display("FAIL rstmid_regrant grant %b adr %h want 010 4000", grant_o, s_adr_o); end
    tick(); cyc[M_IBUS] = 1'b0; stb[M_IBUS] = 1'b0;
    tick(); smp();
    vectors++; if (grant_o !== '0) begin miscompares++; $display("FAIL rstmid_release grant %b want 000", grant_o); end
  endtask
  initial begin
    #1;
    test_reset();
    test_single();
    test_simultaneous();
    test_burst();
    test_timeout();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL global_timeout vectors %0d", vectors);
    $fatal(1, "bench did not complete");
  end
endmodule
